ucaspian_dendrite: RTL and testbench

- Per-neuron charge accumulator directly upstream of the neuron stage.
- Collects weighted synapse events for the next time step into a double-buffered 256-entry charge store.
- On next_step, swaps banks and drains every touched neuron's summed charge to the neuron stage over a valid/ready handshake, in ascending address order.
- Keeps accepting synapse events for the following step into the other bank while draining.

---
 rtl/ucaspian_dendrite.sv | 168 ++++++++++++++++
 tb/tb_ucaspian_dendrite.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucaspian_dendrite.sv
// Double-buffered per-neuron charge accumulator feeding the neuron stage.
// Define UCASPIAN_DENDRITE_SAT_EN for saturating accumulation; default build wraps.
`timescale 1ns/1ps
module ucaspian_dendrite #(
   parameter int ADDR_W   = 8,
   parameter int WEIGHT_W = 8,
   parameter int CHARGE_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                clear_act,
   output logic                clear_done,
   input  logic                next_step,
   output logic                step_done,
   input  logic [ADDR_W-1:0]   syn_addr,
   input  logic [WEIGHT_W-1:0] syn_weight,
   input  logic                syn_vld,
   output logic                syn_rdy,
   output logic [ADDR_W-1:0]   neuron_addr,
   output logic [CHARGE_W-1:0] neuron_charge,
   output logic                neuron_vld,
   input  logic                neuron_rdy
);
   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_FLUSH     = 3'd1;
   localparam logic [2:0] ST_DRAIN_RD  = 3'd2;
   localparam logic [2:0] ST_DRAIN_OUT = 3'd3;
   localparam logic [2:0] ST_CLEAR     = 3'd4;

   logic [2:0]            state_q, state_d;
   logic                  bank_q, bank_d;
   logic                  pend_q, pend_d;
   logic [ADDR_W-1:0]     ptr_q, ptr_d;
   logic [1:0][DEPTH-1:0] vld_q, vld_d;
   logic                  s1_vld_q;
   logic [ADDR_W-1:0]     s1_addr_q;
   logic [WEIGHT_W-1:0]   s1_w_q;
   logic [CHARGE_W-1:0]   s1_old_q;
   logic                  out_vld_q, out_vld_d;
   logic [ADDR_W-1:0]     out_addr_q, out_addr_d;
   logic [CHARGE_W-1:0]   out_chg_q, out_chg_d;
   logic [CHARGE_W-1:0]   mem_q [2][DEPTH];

   logic                  syn_hs, fwd;
   logic [CHARGE_W-1:0]   s2_sum, old_in;

   function automatic logic [CHARGE_W-1:0] acc_add(input logic [CHARGE_W-1:0] a,
                                                   input logic [WEIGHT_W-1:0] w);
      logic signed [CHARGE_W:0] s;
      s = $signed({a[CHARGE_W-1], a}) +
          $signed({{(CHARGE_W+1-WEIGHT_W){w[WEIGHT_W-1]}}, w});
`ifdef UCASPIAN_DENDRITE_SAT_EN
      if (s[CHARGE_W] != s[CHARGE_W-1])
         return s[CHARGE_W] ? {1'b1, {(CHARGE_W-1){1'b0}}} : {1'b0, {(CHARGE_W-1){1'b1}}};
`endif
      return s[CHARGE_W-1:0];
   endfunction

   assign syn_rdy = reset & enable & ~clear_act & (state_q != ST_CLEAR) & (state_q != ST_FLUSH);
   assign syn_hs  = syn_vld & syn_rdy;
   assign s2_sum  = acc_add(s1_old_q, s1_w_q);

   // S2 writes at the end of the cycle a same-address follower is read, so bypass its sum.
   assign fwd    = s1_vld_q & (s1_addr_q == syn_addr);
   assign old_in = fwd ? s2_sum :
                   (vld_q[bank_q][syn_addr] ? mem_q[bank_q][syn_addr] : '0);

   assign step_done     = (state_q == ST_IDLE) & ~s1_vld_q & ~pend_q & ~out_vld_q;
   assign clear_done    = (state_q == ST_CLEAR) & clear_act;
   assign neuron_vld    = out_vld_q;
   assign neuron_addr   = out_addr_q;
   assign neuron_charge = out_chg_q;

   always_ff @(posedge clk) begin
      if (s1_vld_q) mem_q[bank_q][s1_addr_q] <= s2_sum;
   end

   always_comb begin
      state_d    = state_q;
      bank_d     = bank_q;
      pend_d     = pend_q;
      ptr_d      = ptr_q;
      vld_d      = vld_q;
      out_vld_d  = out_vld_q;
      out_addr_d = out_addr_q;
      out_chg_d  = out_chg_q;
      if (s1_vld_q) vld_d[bank_q][s1_addr_q] = 1'b1;
      if (next_step && state_q != ST_IDLE) pend_d = 1'b1;
      case (state_q)
         ST_IDLE: if (next_step || pend_q) begin
            state_d = ST_FLUSH;
            pend_d  = 1'b0;
         end
         ST_FLUSH: if (!s1_vld_q) begin
            bank_d  = ~bank_q;
            ptr_d   = '0;
            state_d = ST_DRAIN_RD;
         end
         ST_DRAIN_RD: if (enable) begin
            if (vld_q[~bank_q][ptr_q]) begin
               out_vld_d  = 1'b1;
               out_addr_d = ptr_q;
               out_chg_d  = mem_q[~bank_q][ptr_q];
               state_d    = ST_DRAIN_OUT;
            end else if (&ptr_q) begin
               state_d = ST_IDLE;
            end else begin
               ptr_d = ptr_q + ADDR_W'(1);
            end
         end
         ST_DRAIN_OUT: if (neuron_rdy) begin
            out_vld_d               = 1'b0;
            vld_d[~bank_q][ptr_q]   = 1'b0;
            if (&ptr_q) begin
               state_d = ST_IDLE;
            end else begin
               ptr_d   = ptr_q + ADDR_W'(1);
               state_d = ST_DRAIN_RD;
            end
         end
         ST_CLEAR: if (!clear_act) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (clear_act) begin
         state_d   = ST_CLEAR;
         bank_d    = 1'b0;
         pend_d    = 1'b0;
         ptr_d     = '0;
         vld_d     = '0;
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         bank_q     <= 1'b0;
         pend_q     <= 1'b0;
         ptr_q      <= '0;
         vld_q      <= '0;
         s1_vld_q   <= 1'b0;
         s1_addr_q  <= '0;
         s1_w_q     <= '0;
         s1_old_q   <= '0;
         out_vld_q  <= 1'b0;
         out_addr_q <= '0;
         out_chg_q  <= '0;
      end else begin
         state_q    <= state_d;
         bank_q     <= bank_d;
         pend_q     <= pend_d;
         ptr_q      <= ptr_d;
         vld_q      <= vld_d;
         s1_vld_q   <= syn_hs;
         if (syn_hs) begin
            s1_addr_q <= syn_addr;
            s1_w_q    <= syn_weight;
            s1_old_q  <= old_in;
         end
         out_vld_q  <= out_vld_d;
         out_addr_q <= out_addr_d;
         out_chg_q  <= out_chg_d;
      end
   end
endmodule

// File: tb/tb_ucaspian_dendrite.sv
// Directed bench for ucaspian_dendrite: vector table of single steps plus multi-cycle corner cases.
`timescale 1ns/1ps
module tb_ucaspian_dendrite;
   logic        clk, reset, enable, clear_act, clear_done, next_step, step_done;
   logic [7:0]  syn_addr, syn_weight, neuron_addr;
   logic        syn_vld, syn_rdy, neuron_vld, neuron_rdy;
   logic [15:0] neuron_charge;

   int checks = 0;
   int errors = 0;

   ucaspian_dendrite dut (
      .clk(clk), .reset(reset), .enable(enable), .clear_act(clear_act),
      .clear_done(clear_done), .next_step(next_step), .step_done(step_done),
      .syn_addr(syn_addr), .syn_weight(syn_weight), .syn_vld(syn_vld), .syn_rdy(syn_rdy),
      .neuron_addr(neuron_addr), .neuron_charge(neuron_charge),
      .neuron_vld(neuron_vld), .neuron_rdy(neuron_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Every accepted drain beat, in order.
   logic [7:0]  qa[$];
   logic [15:0] qc[$];
   always @(negedge clk) begin
      if (reset && neuron_vld && neuron_rdy) begin
         qa.push_back(neuron_addr);
         qc.push_back(neuron_charge);
      end
   end

   typedef struct packed {
      logic [2:0]       n_ev;
      logic [3:0][7:0]  ea;
      logic [3:0][7:0]  ew;
      logic [1:0]       n_out;
      logic [2:0][7:0]  oa;
      logic [2:0][15:0] oc;
   } vec_t;
   vec_t vt[6];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, got, got, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add_ev(input int t, input int k, input logic [7:0] a, input logic [7:0] w);
      vt[t].ea[k] = a;
      vt[t].ew[k] = w;
      vt[t].n_ev  = 3'(k + 1);
   endtask

   task automatic add_out(input int t, input int k, input logic [7:0] a, input logic [15:0] c);
      vt[t].oa[k]  = a;
      vt[t].oc[k]  = c;
      vt[t].n_out  = 2'(k + 1);
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] w);
      int n;
      n = 0;
      syn_addr = a; syn_weight = w; syn_vld = 1'b1;
      @(negedge clk);
      while (!syn_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("send_rdy", syn_rdy, 1);
      step();
      syn_vld = 1'b0;
   endtask

   task automatic pulse();
      next_step = 1'b1;
      step();
      next_step = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!step_done && cyc < bound);
      chk("step_done_reached", step_done, 1);
      step();
   endtask

   task automatic wait_vld(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!neuron_vld && n < 300);
      chk(nm, neuron_vld, 1);
   endtask

   initial begin
      int cyc;
      logic stable;
      logic [15:0] exp_sat;

      for (int t = 0; t < 6; t++) vt[t] = '0;
      add_ev(0, 0, 8'd5, 8'd10);   add_ev(0, 1, 8'd5, 8'd20);  add_ev(0, 2, 8'd9, 8'hFD);
      add_out(0, 0, 8'd5, 16'd30); add_out(0, 1, 8'd9, 16'hFFFD);
      add_ev(1, 0, 8'd7, 8'd1);    add_ev(1, 1, 8'd7, 8'd2);   add_ev(1, 2, 8'd7, 8'd3);
      add_ev(1, 3, 8'd7, 8'd4);    add_out(1, 0, 8'd7, 16'd10);
      add_ev(2, 0, 8'd255, 8'h80); add_ev(2, 1, 8'd0, 8'd127); add_ev(2, 2, 8'd255, 8'hFF);
      add_ev(2, 3, 8'd5, 8'd1);
      add_out(2, 0, 8'd0, 16'd127); add_out(2, 1, 8'd5, 16'd1); add_out(2, 2, 8'd255, 16'hFF7F);
      add_ev(3, 0, 8'd1, 8'd5);    add_ev(3, 1, 8'd2, 8'd6);   add_ev(3, 2, 8'd1, 8'hFB);
      add_out(3, 0, 8'd1, 16'd0);  add_out(3, 1, 8'd2, 16'd6);
      add_ev(4, 0, 8'd4, 8'd3);    add_ev(4, 1, 8'd8, 8'd1);   add_ev(4, 2, 8'd4, 8'd4);
      add_out(4, 0, 8'd4, 16'd7);  add_out(4, 1, 8'd8, 16'd1);

      reset = 1'b0; enable = 1'b1; clear_act = 1'b0; next_step = 1'b0;
      syn_addr = '0; syn_weight = '0; syn_vld = 1'b0; neuron_rdy = 1'b1;
      @(negedge clk);
      chk("rst_syn_rdy", syn_rdy, 0);
      chk("rst_neuron_vld", neuron_vld, 0);
      chk("rst_neuron_addr", neuron_addr, 0);
      chk("rst_neuron_charge", neuron_charge, 0);
      chk("rst_clear_done", clear_done, 0);
      chk("rst_step_done", step_done, 1);
      step();
      reset = 1'b1;
      step();

      for (int t = 0; t < 6; t++) begin
         qa.delete(); qc.delete();
         for (int k = 0; k < int'(vt[t].n_ev); k++) send(vt[t].ea[k], vt[t].ew[k]);
         pulse();
         wait_done(400, cyc);
         if (t == 0) chk("v0_done_within_260", cyc <= 260, 1);
         chk($sformatf("v%0d_count", t), qa.size(), vt[t].n_out);
         for (int k = 0; k < int'(vt[t].n_out); k++) begin
            chk($sformatf("v%0d_addr%0d", t, k), (k < qa.size()) ? {24'd0, qa[k]} : 32'hDEAD, vt[t].oa[k]);
            chk($sformatf("v%0d_chg%0d", t, k), (k < qc.size()) ? {16'd0, qc[k]} : 32'hDEAD, vt[t].oc[k]);
         end
      end

      // 300 x +127 to address 0: overflow handling.
`ifdef UCASPIAN_DENDRITE_SAT_EN
      exp_sat = 16'h7FFF;
`else
      exp_sat = 16'h94D4;
`endif
      qa.delete(); qc.delete();
      for (int i = 0; i < 300; i++) send(8'd0, 8'd127);
      pulse();
      wait_done(400, cyc);
      chk("sat_count", qa.size(), 1);
      chk("sat_chg", (qc.size() > 0) ? {16'd0, qc[0]} : 32'hDEAD, exp_sat);

      // Backpressure with overlapped accumulation into the other bank.
      qa.delete(); qc.delete();
      send(8'd3, 8'd50);
      neuron_rdy = 1'b0;
      pulse();
      wait_vld("bp_vld_seen");
      step();
      send(8'd3, 8'd7);
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         stable &= neuron_vld && neuron_addr == 8'd3 && neuron_charge == 16'd50;
         step();
      end
      chk("bp_held_stable", stable, 1);
      neuron_rdy = 1'b1;
      wait_done(400, cyc);
      chk("bp_count1", qa.size(), 1);
      chk("bp_chg1", (qc.size() > 0) ? {16'd0, qc[0]} : 32'hDEAD, 50);
      qa.delete(); qc.delete();
      pulse();
      wait_done(400, cyc);
      chk("bp_count2", qa.size(), 1);
      chk("bp_chg2", (qc.size() > 0) ? {16'd0, qc[0]} : 32'hDEAD, 7);

      // Clear during the second drain handshake.
      qa.delete(); qc.delete();
      send(8'd10, 8'd1); send(8'd20, 8'd2); send(8'd30, 8'd3);
      neuron_rdy = 1'b0;
      pulse();
      wait_vld("clr_vld1");
      chk("clr_addr1", neuron_addr, 10);
      step();
      neuron_rdy = 1'b1;
      step();
      neuron_rdy = 1'b0;
      wait_vld("clr_vld2");
      chk("clr_addr2", neuron_addr, 20);
      step();
      neuron_rdy = 1'b1; clear_act = 1'b1;
      @(negedge clk);
      chk("clr_done_first_cycle", clear_done, 0);
      step();
      @(negedge clk);
      chk("clr_vld_dropped", neuron_vld, 0);
      chk("clr_done_second_cycle", clear_done, 1);
      step(); step();
      @(negedge clk);
      chk("clr_done_held", clear_done, 1);
      step();
      clear_act = 1'b0;
      @(negedge clk);
      chk("clr_done_fall", clear_done, 0);
      step();
      chk("clr_beats", qa.size(), 2);
      pulse();
      wait_done(400, cyc);
      chk("clr_no_output", qa.size(), 2);

      // Two pulses during a drain merge into exactly one extra pass.
      qa.delete(); qc.delete();
      send(8'd40, 8'd1); send(8'd50, 8'd2);
      pulse();
      cyc = 0;
      while (cyc < 700) begin
         next_step = (cyc == 10 || cyc == 30);
         @(negedge clk);
         cyc++;
         if (step_done) break;
         step();
      end
      next_step = 1'b0;
      chk("pend_two_passes", cyc >= 516 && cyc <= 520, 1);
      chk("pend_count", qa.size(), 2);
      step();

      // Reset mid-drain.
      qa.delete(); qc.delete();
      send(8'd60, 8'd5);
      neuron_rdy = 1'b0;
      pulse();
      wait_vld("rst_mid_vld");
      step();
      reset = 1'b0;
      #1;
      chk("rst_mid_neuron_vld", neuron_vld, 0);
      chk("rst_mid_step_done", step_done, 1);
      chk("rst_mid_syn_rdy", syn_rdy, 0);
      step();
      reset = 1'b1; neuron_rdy = 1'b1;
      step();
      pulse();
      wait_done(400, cyc);
      chk("rst_mid_no_output", qa.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
